tick_pwm_generator: RTL

Tick-driven PWM generator that sits directly downstream of the static clock divider. It consumes the divider's one-cycle enable pulse as its time base and produces a pulse-width-modulated output, with period and duty programmable at run time. Updates made while running are double-buffered and take effect only at a period boundary, so the output never glitches. Typical users are LED dimming, motor drive and buzzer outputs, with period/duty written from a register bank.

---
 rtl/tick_pwm_generator.sv | 103 ++++++++++
 1 files changed

// File: rtl/tick_pwm_generator.sv
// Tick-driven PWM generator with double-buffered period/duty updates.
// Consumes a one-cycle time-base strobe; all outputs are registered.
module tick_pwm_generator #(
    parameter int p_WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RESET_N,
    input  logic               i_ENABLE,
    input  logic               i_TICK,
    input  logic               i_LOAD,
    input  logic [p_WIDTH-1:0] i_PERIOD,
    input  logic [p_WIDTH-1:0] i_DUTY,
    output logic               o_PWM,
    output logic               o_PERIOD_DONE,
    output logic               o_LOAD_PENDING
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_State;
    logic [p_WIDTH-1:0] r_Period;
    logic [p_WIDTH-1:0] r_Duty;
    logic [p_WIDTH-1:0] r_PendPeriod;
    logic [p_WIDTH-1:0] r_PendDuty;
    logic [p_WIDTH-1:0] r_Count;
    logic               r_Pend;
    logic               r_Pwm;
    logic               r_Done;

    logic w_Step;
    logic w_Wrap;

    // >= lets a period shrunk below the current count wrap on the next tick
    always_comb begin
        w_Step = (r_State == RUN) && i_ENABLE && i_TICK;
        w_Wrap = w_Step && (r_Count >= r_Period);
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET_N) begin
            r_State      <= IDLE;
            r_Period     <= '0;
            r_Duty       <= '0;
            r_PendPeriod <= '0;
            r_PendDuty   <= '0;
            r_Count      <= '0;
            r_Pend       <= 1'b0;
            r_Pwm        <= 1'b0;
            r_Done       <= 1'b0;
        end else begin
            r_Done <= w_Wrap;
            r_Pwm  <= (r_State == RUN) && (r_Count < r_Duty);
            case (r_State)
                IDLE: begin
                    r_Count <= '0;
                    if (i_LOAD) begin
                        r_Period <= i_PERIOD;
                        r_Duty   <= i_DUTY;
                        r_Pend   <= 1'b0;
                    end
                    if (i_ENABLE) begin
                        r_State <= RUN;
                    end
                end
                RUN: begin
                    if (!i_ENABLE) begin
                        r_State <= IDLE;
                        r_Count <= '0;
                    end else if (w_Wrap) begin
                        r_Count <= '0;
                    end else if (w_Step) begin
                        r_Count <= r_Count + p_WIDTH'(1);
                    end
                    // a load on the wrap tick bypasses the pending buffer
                    if (w_Wrap && i_LOAD) begin
                        r_Period <= i_PERIOD;
                        r_Duty   <= i_DUTY;
                        r_Pend   <= 1'b0;
                    end else if (w_Wrap && r_Pend) begin
                        r_Period <= r_PendPeriod;
                        r_Duty   <= r_PendDuty;
                        r_Pend   <= 1'b0;
                    end else if (i_LOAD) begin
                        r_PendPeriod <= i_PERIOD;
                        r_PendDuty   <= i_DUTY;
                        r_Pend       <= 1'b1;
                    end
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign o_PWM          = r_Pwm;
    assign o_PERIOD_DONE  = r_Done;
    assign o_LOAD_PENDING = r_Pend;

endmodule
